// File: rtl/debug_pkg.sv
// Shared types and constants for the debug nibble-stream receiver.
// Holds mode encodings, frame lengths, the mode->length helper and the
// record struct carried through the receive FIFO.
package debug_pkg;

  localparam logic [1:0] MODE_PC       = 2'd0;
  localparam logic [1:0] MODE_PC_INSTR = 2'd1;
  localparam logic [1:0] MODE_ALL      = 2'd2;

  localparam int unsigned LEN_PC       = 8;
  localparam int unsigned LEN_PC_INSTR = 16;
  localparam int unsigned LEN_ALL      = 24;

  // Wide enough to hold any nibble index / frame length (max 24).
  localparam int unsigned CNT_W = 5;

  // One reassembled debug record (98 bits).
  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] pc;
  } debug_rec_t;

  // Frame length in nibbles for a given mode; mode 3 behaves as PC-only.
  function automatic logic [CNT_W-1:0] mode_len(input logic [1:0] m);
    case (m)
      MODE_PC_INSTR: return CNT_W'(LEN_PC_INSTR);
      MODE_ALL:      return CNT_W'(LEN_ALL);
      default:       return CNT_W'(LEN_PC);
    endcase
  endfunction

endpackage

// File: rtl/debug_input_if.sv
// Record output bus of the debug receiver (valid/ready handshake).
// master: drives m_valid and the record fields, samples m_ready.
// slave : consumer side (UART bridge / ILA capture).
interface debug_input_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_wdata;
  logic [1:0]  m_mode;

  modport master (output m_valid, output m_pc, output m_instr,
                  output m_wdata, output m_mode, input m_ready);
  modport slave  (input m_valid, input m_pc, input m_instr,
                  input m_wdata, input m_mode, output m_ready);
endinterface

// File: rtl/debug_rec_fifo.sv
// Show-ahead synchronous FIFO of debug records.
// Ports: clk, rst_n; push/wdata/full on the write side; pop/empty/head on
// the read side. head is read straight from register storage, so a record
// pushed at edge N is visible right after N. A pop and push in the same
// cycle are both honoured even when full.
module debug_rec_fifo
  import debug_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  debug_rec_t wdata,
  output logic       full,
  input  logic       pop,
  output logic       empty,
  output debug_rec_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  debug_rec_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  // Occupancy update.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/debug_input.sv
// Receive-side deserializer for the 4-bit debug nibble stream.
// Ports: clk, rst_n; mode/rx_data/rx_active from the serializer; m (record
// bus, master side); err_short / err_overflow one-cycle error pulses;
// drop_cnt saturating count of discarded records.
module debug_input
  import debug_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [3:0]            rx_data,
  input  logic                  rx_active,
  debug_input_if.master         m,
  output logic                  err_short,
  output logic                  err_overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned ASM_W = 96;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [ASM_W-1:0]      asm_q, asm_d;
  logic                  err_short_q, err_overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  complete_c, short_c, ovf_c, push_c, pop_c;
  logic [6:0]            nib_idx_c;
  debug_rec_t            rec_c, head;
  logic                  fifo_full, fifo_empty;

  assign nib_idx_c = {cnt_q, 2'b00};

  // Frame assembly FSM: next state, counter and assembly register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mode_d     = mode_q;
    asm_d      = asm_q;
    complete_c = 1'b0;
    short_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_active) begin
          mode_d       = (mode == 2'd3) ? MODE_PC : mode;
          len_d        = mode_len(mode);
          asm_d        = '0;
          asm_d[3:0]   = rx_data;
          cnt_d        = CNT_W'(1);
          state_d      = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_active) begin
          asm_d[nib_idx_c +: 4] = rx_data;
          if (cnt_q == len_q - CNT_W'(1)) begin
            complete_c = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          short_c = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Record includes the nibble arriving on the completion cycle.
  always_comb begin
    rec_c.pc    = asm_d[31:0];
    rec_c.instr = asm_d[63:32];
    rec_c.wdata = asm_d[95:64];
    rec_c.mode  = mode_q;
  end

  // A full FIFO still accepts a record if the head leaves on the same edge.
  assign pop_c  = m.m_valid && m.m_ready;
  assign ovf_c  = complete_c && fifo_full && !pop_c;
  assign push_c = complete_c && !ovf_c;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((short_c || ovf_c) && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= CNT_W'(LEN_PC);
      mode_q         <= MODE_PC;
      asm_q          <= '0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      mode_q         <= mode_d;
      asm_q          <= asm_d;
      err_short_q    <= short_c;
      err_overflow_q <= ovf_c;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  debug_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (rec_c),
    .full  (fifo_full),
    .pop   (pop_c),
    .empty (fifo_empty),
    .head  (head)
  );

  assign m.m_valid    = !fifo_empty;
  assign m.m_pc       = head.pc;
  assign m.m_instr    = head.instr;
  assign m.m_wdata    = head.wdata;
  assign m.m_mode     = head.mode;
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_debug_input.sv
// Bench for debug_input: directed frames, scoreboard queues of expected
// records and expected error pulses, negedge monitor doing the compares.
module tb_debug_input;
  import debug_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [3:0]  rx_data;
  logic        rx_active;
  logic        err_short;
  logic        err_overflow;
  logic [15:0] drop_cnt;

  debug_input_if bus ();

  debug_input #(.FIFO_DEPTH(4), .DROP_CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .rx_data      (rx_data),
    .rx_active    (rx_active),
    .m            (bus),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  debug_rec_t exp_q[$];
  logic [1:0] err_q[$];   // 2'b01 = short, 2'b10 = overflow

  function automatic debug_rec_t mk(input logic [1:0] md, input logic [31:0] pc,
                                    input logic [31:0] instr, input logic [31:0] wdata);
    debug_rec_t r;
    r.mode  = (md == 2'd3) ? 2'd0 : md;
    r.pc    = pc;
    r.instr = (r.mode != 2'd0) ? instr : 32'h0;
    r.wdata = (r.mode == 2'd2) ? wdata : 32'h0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: compares accepted records and error pulses against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        debug_rec_t got, e;
        got = '{mode: bus.m_mode, wdata: bus.m_wdata, instr: bus.m_instr, pc: bus.m_pc};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_record: got pc=%h instr=%h wdata=%h mode=%0d",
                   got.pc, got.instr, got.wdata, got.mode);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL record: got pc=%h instr=%h wdata=%h mode=%0d want pc=%h instr=%h wdata=%h mode=%0d",
                     got.pc, got.instr, got.wdata, got.mode, e.pc, e.instr, e.wdata, e.mode);
          end
        end
      end
      if (err_short || err_overflow) begin
        logic [1:0] ek;
        n_cmp++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err: got ovf=%b short=%b", err_overflow, err_short);
        end else begin
          ek = err_q.pop_front();
          if ({err_overflow, err_short} !== ek) begin
            n_fail++;
            $display("FAIL err_kind: got %b want %b", {err_overflow, err_short}, ek);
          end
        end
      end
    end
  end

  task automatic go_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_active = 1'b0;
      rx_data   = 4'h0;
    end
  endtask

  // Drive nnib nibbles LSB-first; optionally switch mode at nibble chg_at
  // and raise m_ready together with the last nibble.
  task automatic send_frame(input logic [1:0] md, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] wdata,
                            input int nnib, input int chg_at, input logic [1:0] chg_md,
                            input bit rdy_last);
    logic [95:0] w;
    logic [1:0]  cur;
    w   = {wdata, instr, pc};
    cur = md;
    for (int k = 0; k < nnib; k++) begin
      if (k == chg_at) cur = chg_md;
      @(posedge clk); #1;
      mode      = cur;
      rx_data   = w[4*k +: 4];
      rx_active = 1'b1;
      if (rdy_last && (k == nnib - 1)) bus.m_ready = 1'b1;
    end
  endtask

  logic [31:0] pcs [6];

  initial begin
    rst_n       = 1'b0;
    mode        = 2'd0;
    rx_data     = 4'h0;
    rx_active   = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
    chk("rst_m_pc", bus.m_pc, 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 1 frame, consumer always ready.
    bus.m_ready = 1'b1;
    exp_q.push_back(mk(2'd1, 32'h1C000004, 32'h02800C0C, 32'h0));
    send_frame(2'd1, 32'h1C000004, 32'h02800C0C, 32'h0, 16, -1, 2'd0, 1'b0);
    go_idle(1);
    chk("t1_valid_after_last", 32'(bus.m_valid), 32'h1);
    go_idle(1);
    chk("t1_valid_one_cycle", 32'(bus.m_valid), 32'h0);

    // Mode 2 frame, then a frame whose mode input changes mid-flight.
    exp_q.push_back(mk(2'd2, 32'h1C000010, 32'h0015002C, 32'hDEADBEEF));
    send_frame(2'd2, 32'h1C000010, 32'h0015002C, 32'hDEADBEEF, 24, -1, 2'd0, 1'b0);
    exp_q.push_back(mk(2'd2, 32'h11112222, 32'h33334444, 32'h55556666));
    send_frame(2'd2, 32'h11112222, 32'h33334444, 32'h55556666, 24, 5, 2'd0, 1'b0);
    go_idle(3);

    // Truncated mode-0 frame, then a full all-zero frame.
    err_q.push_back(2'b01);
    send_frame(2'd0, 32'h87654321, 32'h0, 32'h0, 5, -1, 2'd0, 1'b0);
    go_idle(3);
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    exp_q.push_back(mk(2'd0, 32'h0, 32'h0, 32'h0));
    send_frame(2'd0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, -1, 2'd0, 1'b0);
    go_idle(3);
    chk("t3_drained", 32'(bus.m_valid), 32'h0);

    // Six back-to-back mode-0 frames into a stalled depth-4 FIFO.
    bus.m_ready = 1'b0;
    pcs = '{32'hA0000001, 32'hA0000002, 32'hA0000003,
            32'hA0000004, 32'hA0000005, 32'hA0000006};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(mk(2'd0, pcs[i], 32'h0, 32'h0));
      else       err_q.push_back(2'b10);
      send_frame(2'd0, pcs[i], 32'h0, 32'h0, 8, -1, 2'd0, 1'b0);
    end
    go_idle(3);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("t4_valid_held", 32'(bus.m_valid), 32'h1);
    chk("t4_head_stable", bus.m_pc, pcs[0]);

    // Full FIFO, consumer accepts on the completion cycle: no drop.
    exp_q.push_back(mk(2'd3, 32'hB0000007, 32'h0, 32'h0));
    send_frame(2'd3, 32'hB0000007, 32'h0, 32'h0, 8, -1, 2'd0, 1'b1);
    @(posedge clk); #1;
    rx_active   = 1'b0;
    bus.m_ready = 1'b0;
    go_idle(2);
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("t5_head", bus.m_pc, pcs[1]);
    bus.m_ready = 1'b1;
    go_idle(6);
    chk("t5_drained", 32'(bus.m_valid), 32'h0);

    // Asynchronous reset in the middle of a mode-2 frame.
    bus.m_ready = 1'b0;
    send_frame(2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 8, -1, 2'd0, 1'b0);
    go_idle(2);
    chk("t6_pre_valid", 32'(bus.m_valid), 32'h1);
    send_frame(2'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 10, -1, 2'd0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.m_valid), 32'h0);
    chk("t6_rst_pc", bus.m_pc, 32'h0);
    chk("t6_rst_instr", bus.m_instr, 32'h0);
    chk("t6_rst_wdata", bus.m_wdata, 32'h0);
    chk("t6_rst_mode", 32'(bus.m_mode), 32'h0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'h0);
    chk("t6_rst_err", 32'({err_short, err_overflow}), 32'h0);
    rx_active = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    exp_q.push_back(mk(2'd2, 32'h2468ACE0, 32'h13579BDF, 32'hFEDCBA98));
    send_frame(2'd2, 32'h2468ACE0, 32'h13579BDF, 32'hFEDCBA98, 24, -1, 2'd0, 1'b0);
    go_idle(4);
    chk("t6_drop_after", 32'(drop_cnt), 32'h0);

    chk("end_records_left", 32'(exp_q.size()), 32'h0);
    chk("end_errs_left", 32'(err_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_input.md
Name: debug_input

Overview:
- Receive-side deserializer for the 4-bit debug nibble stream produced by the core-side debug serializer.
- Reassembles each frame into a {pc, instr, wdata} record, buffers completed records in a small FIFO and presents them on a valid/ready interface to the debug host logic (UART bridge or ILA capture).
- Flags truncated frames and FIFO overflow.

Parameters:
- FIFO_DEPTH, 4, number of completed records buffered; must be a power of two, at least 2.
- DROP_CNT_W, 16, width of the saturating dropped-record counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low; deassertion assumed synchronized externally.
- mode  input  2  frame format, same encoding as the serializer: 0 = PC only (8 nibbles), 1 = PC+instr (16), 2 = PC+instr+wdata (24), 3 = treated as 0.
- rx_data  input  4  nibble lane from the serializer.
- rx_active  input  1  high on every cycle carrying a nibble of a frame.
- m_valid  output  1  FIFO head record valid.
- m_ready  input  1  consumer accepts the head record when m_valid && m_ready.
- m_pc  output  32  head record PC.
- m_instr  output  32  head record instruction; 0 in mode 0.
- m_wdata  output  32  head record regfile write data; 0 in modes 0/1.
- m_mode  output  2  mode the head record was received in (3 stored as 0).
- err_short  output  1  one-cycle pulse: frame truncated, record discarded.
- err_overflow  output  1  one-cycle pulse: completed record dropped because FIFO full.
- drop_cnt  output  DROP_CNT_W  saturating count of all discarded records (short + overflow).

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, nibble counter 0, assembly register 0, FIFO empty; m_valid=0, m_pc/m_instr/m_wdata=0, m_mode=0, err_short=0, err_overflow=0, drop_cnt=0. Reset mid-frame abandons the frame without an error pulse.
- Nibble order is LSB-first: index k carries bits [4k+3:4k] of the 96-bit word {wdata, instr, pc}. PC occupies nibbles 0-7, instr 8-15, wdata 16-23.
- Frame length L = 8 / 16 / 24 for modes 0 / 1 / 2 (3 maps to 8). L and the mode are latched on the first nibble; later changes to mode do not affect the frame in flight.
- IDLE, rx_active=1: latch mode, clear assembly register, store nibble 0, cnt=1, go to RECV.
- RECV, rx_active=1: store nibble at index cnt.
  - If cnt==L-1: frame complete; record written to FIFO on the same clock edge, go to IDLE.
  - Otherwise cnt+1.
- RECV, rx_active=0: truncated frame; err_short=1 next cycle, drop_cnt+1, go to IDLE, nothing written.
- rx_active high on the cycle immediately after completion starts a new frame. There is no overlong-frame error: excess nibbles form the next frame.
- Unreceived fields are 0 in the record.
- Latency: last nibble sampled at edge N; m_valid=1 after edge N when the FIFO was empty. The FIFO is show-ahead, with registered outputs from FIFO storage.
- FIFO full at completion:
  - If m_valid && m_ready in the same cycle, pop and push both occur and no drop.
  - Otherwise the record is dropped: err_overflow=1 next cycle, drop_cnt+1.
- Pop when m_valid && m_ready. m_ready while empty has no effect.
- Outputs are stable while m_valid=1 && m_ready=0.
- drop_cnt saturates at all-ones. Simultaneous short and overflow events are impossible, because only one frame resolves per cycle.
- The error pulses are registered and last exactly one cycle.

Decomposition:
- Package debug_pkg:
  - mode encoding constants: MODE_PC=0, MODE_PC_INSTR=1, MODE_ALL=2;
  - nibble-count constants 8/16/24;
  - function mode_len(mode) returning L;
  - struct debug_rec_t {pc, instr, wdata, mode}, 98 bits.
- Sub-module debug_rec_fifo:
  - synchronous FIFO of debug_rec_t;
  - parameter DEPTH;
  - push/full, pop/empty, show-ahead head;
  - same clk/rst_n.
- Top-level debug_input holds the FSM, counter, assembly register and error/drop logic.

Test Plan:
- Mode 1, pc=0x1C000004, instr=0x02800C0C sent as 16 LSB-first nibbles, m_ready=1 -> m_valid for 1 cycle, one cycle after the last nibble, with m_pc=0x1C000004, m_instr=0x02800C0C, m_wdata=0, m_mode=1.
- Mode 2, pc=0x1C000010, instr=0x0015002C, wdata=0xDEADBEEF -> matching record; then mode changed to 0 mid-frame of a second frame -> second frame still 24 nibbles with m_mode=2.
- Mode 0 frame with rx_active dropped after 5 nibbles -> err_short pulse, drop_cnt=1, no m_valid; the next full 8-nibble frame pc=0x00000000 -> record pc=0, err_short=0.
- m_ready=0, six back-to-back mode-0 frames, FIFO_DEPTH=4 -> 4 records held in order; err_overflow pulses twice, drop_cnt=2; then m_ready=1 -> records 1-4 drain in order.
- FIFO full with m_ready=1 on the completion cycle -> no overflow, count stays 4, order preserved.
- rst_n asserted at nibble 10 of a mode-2 frame -> all outputs 0 immediately (asynchronous); after release, a fresh frame is captured correctly with no error pulse.
